fp_int_converter: RTL and testbench
===================================

FP_INT_CONVERTER -- requirements
Module: fp_int_converter

Interface
REQ-001 No parameters; operand width fixed at 32 bits (IEEE-754 single, RV32 integer).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 FCVT.W.S, 01 FCVT.WU.S, 10 FCVT.S.W, 11 FCVT.S.WU.
REQ-006 operand  input  32  float bits (ops 00/01) or integer (ops 10/11).
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 done  output  1  one-cycle pulse when result is valid.
REQ-009 result  output  32  converted value; holds until the next done.
REQ-010 invalid  output  1  NV flag for the last conversion; valid with done.

Function
REQ-011 States: IDLE, SHIFT, PACK.
REQ-012 Transitions: IDLE->SHIFT on start; SHIFT->PACK when cnt==0; PACK->IDLE unconditionally.
REQ-013 Start seen in a non-IDLE state is ignored; start in the done cycle is accepted (state is IDLE).
REQ-014 In SHIFT, the working register shifts 1 bit per cycle and cnt decrements; N = number of shift steps.
REQ-015 Latency: start sampled at edge 0; done high after edge N+2; result/invalid registered at the same edge.
REQ-016 Float->int: e=operand[30:23]; m={1,frac} in 32-bit register; N=|150-e|; right shift if e<=150, else left shift.
REQ-017 Float->int special cases load with N=0: e<127 gives 0 (RTZ); NaN gives 0x7FFFFFFF (W) or 0xFFFFFFFF (WU) with invalid=1; +/-0 gives 0.
REQ-018 W overflow: e>=158 gives 0x7FFFFFFF if positive, 0x80000000 if negative, invalid=1; exception: operand 0xCF000000 gives 0x80000000 with invalid=0.
REQ-019 WU: e>=159 and positive gives 0xFFFFFFFF with invalid=1; negative with e>=127 gives 0 with invalid=1; otherwise the result is the unsigned magnitude.
REQ-020 W negative result = two's complement of the shifted magnitude, applied in PACK.
REQ-021 Int->float: magnitude = |operand| (S.W) or operand (S.WU); 0 gives 0x00000000 with N=0.
REQ-022 Int->float normalize: shift left until bit31=1; N = leading-zero count; exp=158-N; frac=mag[30:8] (truncate, RTZ); sign = operand[31] for S.W only.
REQ-023 Int->float sets invalid=0 always; rounding is round-toward-zero for all ops.
REQ-024 done is high exactly one cycle per accepted start; busy is low in that cycle.

Reset
REQ-025 reset forces state=IDLE, busy=0, done=0, result=0, invalid=0, cnt=0.
REQ-026 reset mid-conversion aborts it; no done is produced for the aborted request.
REQ-027 reset has priority over start in the same cycle.

Structure
REQ-028 Package fcvt_pkg holds: op encodings, state enum, BIAS=127, INT_EXP_TOP=158, FRAC_W=23.
REQ-029 Single module, no sub-module; the shifter is the shared working register plus cnt.

Verification
REQ-030 W, 0x40490FDB (3.14159) -> result 0x00000003, invalid=0, done 24 cycles after start (N=22).
REQ-031 W, 0xC2F6E979 (-123.456) -> 0xFFFFFF85; W, 0x4F000000 -> 0x7FFFFFFF invalid=1; 0xCF000000 -> 0x80000000 invalid=0; 0x7FC00000 -> 0x7FFFFFFF invalid=1.
REQ-032 S.W, 0x00000001 -> 0x3F800000 with latency 33; S.W 0x80000000 -> 0xCF000000 with latency 2; S.WU 0xFFFFFFFF -> 0x4F7FFFFF.
REQ-033 WU, 0xBF800000 (-1.0) -> 0 invalid=1; WU, 0xBF000000 (-0.5) -> 0 invalid=0.
REQ-034 Start pulsed while busy -> ignored, single done; start in done cycle -> second conversion accepted back-to-back.
REQ-035 reset asserted during SHIFT -> next cycle all outputs 0, no done pulse; a fresh start afterwards converts correctly.

Source files
------------

// File: rtl/fcvt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcvt_pkg
// Description : Shared encodings, constants and helpers for fp_int_converter.
// Revision    : 1.0 - initial release
// ============================================================================
package fcvt_pkg;

    localparam logic [1:0] OP_W_S  = 2'b00;
    localparam logic [1:0] OP_WU_S = 2'b01;
    localparam logic [1:0] OP_S_W  = 2'b10;
    localparam logic [1:0] OP_S_WU = 2'b11;

    localparam logic [7:0] BIAS        = 8'd127;
    localparam logic [7:0] INT_EXP_TOP = 8'd158;
    localparam int         FRAC_W      = 23;
    // Exponent at which the 24-bit significand already sits at the integer LSB.
    localparam logic [7:0] SHIFT_PIVOT = BIAS + 8'(FRAC_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PACK  = 2'd2
    } state_e;

    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_int_converter.sv
`default_nettype none
// ============================================================================
// Module      : fp_int_converter
// Description : Multi-cycle RV32 FCVT.{W,WU}.S / FCVT.S.{W,WU} converter using
//               a single 1-bit-per-cycle working shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_int_converter
    import fcvt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;
    logic        left_q, left_d;
    logic        neg_q, neg_d;
    logic        bypass_q, bypass_d;
    logic        inv_q, inv_d;
    logic        to_float_q, to_float_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        invalid_q, invalid_d;

    logic              f_sign;
    logic [7:0]        f_exp;
    logic [FRAC_W-1:0] f_frac;
    logic              f_nan;
    logic              int_neg;
    logic [31:0]       int_mag;
    logic [4:0]        int_lzc;
    logic [7:0]        pivot_diff;

    logic [31:0] ld_work;
    logic [4:0]  ld_cnt;
    logic        ld_left;
    logic        ld_neg;
    logic        ld_bypass;
    logic        ld_inv;
    logic        ld_to_float;
    logic        ld_sign;
    logic [7:0]  ld_exp;

    // Operand decode: special cases preload the final value with a zero count.
    always_comb begin
        f_sign     = operand[31];
        f_exp      = operand[30:23];
        f_frac     = operand[FRAC_W-1:0];
        f_nan      = (f_exp == 8'hFF) && (f_frac != '0);
        int_neg    = (op == OP_S_W) && operand[31];
        int_mag    = int_neg ? (~operand + 32'd1) : operand;
        int_lzc    = lzc32(int_mag);
        pivot_diff = (f_exp > SHIFT_PIVOT) ? (f_exp - SHIFT_PIVOT) : (SHIFT_PIVOT - f_exp);

        ld_work     = {8'd0, 1'b1, f_frac};
        ld_cnt      = pivot_diff[4:0];
        ld_left     = (f_exp > SHIFT_PIVOT);
        ld_neg      = 1'b0;
        ld_bypass   = 1'b0;
        ld_inv      = 1'b0;
        ld_to_float = 1'b0;
        ld_sign     = 1'b0;
        ld_exp      = '0;

        case (op)
            OP_W_S, OP_WU_S: begin
                if (f_nan) begin
                    ld_bypass = 1'b1;
                    ld_cnt    = '0;
                    ld_work   = (op == OP_W_S) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
                    ld_inv    = 1'b1;
                end else if (f_exp < BIAS) begin
                    ld_bypass = 1'b1;
                    ld_cnt    = '0;
                    ld_work   = '0;
                end else if (op == OP_W_S) begin
                    if (f_exp >= INT_EXP_TOP) begin
                        ld_bypass = 1'b1;
                        ld_cnt    = '0;
                        ld_work   = f_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        // -2^31 is exactly representable and is not an overflow.
                        ld_inv    = (operand != 32'hCF00_0000);
                    end else begin
                        ld_neg = f_sign;
                    end
                end else if (f_sign) begin
                    ld_bypass = 1'b1;
                    ld_cnt    = '0;
                    ld_work   = '0;
                    ld_inv    = 1'b1;
                end else if (f_exp > INT_EXP_TOP) begin
                    ld_bypass = 1'b1;
                    ld_cnt    = '0;
                    ld_work   = 32'hFFFF_FFFF;
                    ld_inv    = 1'b1;
                end
            end
            default: begin
                ld_to_float = 1'b1;
                ld_left     = 1'b1;
                ld_sign     = int_neg;
                ld_work     = int_mag;
                ld_cnt      = int_lzc;
                ld_exp      = INT_EXP_TOP - {3'd0, int_lzc};
                if (int_mag == '0) begin
                    ld_bypass = 1'b1;
                    ld_cnt    = '0;
                    ld_sign   = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        left_d     = left_q;
        neg_d      = neg_q;
        bypass_d   = bypass_q;
        inv_d      = inv_q;
        to_float_d = to_float_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        done_d     = 1'b0;
        result_d   = result_q;
        invalid_d  = invalid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = ld_cnt;
                    work_d     = ld_work;
                    left_d     = ld_left;
                    neg_d      = ld_neg;
                    bypass_d   = ld_bypass;
                    inv_d      = ld_inv;
                    to_float_d = ld_to_float;
                    sign_d     = ld_sign;
                    exp_d      = ld_exp;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_PACK;
                end else begin
                    cnt_d  = cnt_q - 5'd1;
                    work_d = left_q ? (work_q << 1) : (work_q >> 1);
                end
            end
            ST_PACK: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                invalid_d = inv_q;
                if (bypass_q)        result_d = work_q;
                else if (to_float_q) result_d = {sign_q, exp_q, work_q[30 -: FRAC_W]};
                else if (neg_q)      result_d = ~work_q + 32'd1;
                else                 result_d = work_q;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            left_q     <= 1'b0;
            neg_q      <= 1'b0;
            bypass_q   <= 1'b0;
            inv_q      <= 1'b0;
            to_float_q <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            left_q     <= left_d;
            neg_q      <= neg_d;
            bypass_q   <= bypass_d;
            inv_q      <= inv_d;
            to_float_q <= to_float_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            invalid_q  <= invalid_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign invalid = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_int_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_int_converter
// Description : Directed self-checking bench for fp_int_converter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_int_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;

    int checks;
    int failures;

    fp_int_converter u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called #1 after a rising edge; start is seen at the next edge (edge 0).
    task automatic run_conv(input string tag, input logic [1:0] o, input logic [31:0] opd,
                            input logic [31:0] exp_res, input logic exp_inv, input int exp_lat);
        int lat;
        op      = o;
        operand = opd;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_inv"}, {31'd0, invalid}, {31'd0, exp_inv});
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          n_done;
        logic [31:0] got;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        operand  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",    {31'd0, busy},    32'd0);
        check_eq("rst_done",    {31'd0, done},    32'd0);
        check_eq("rst_result",  result,           32'd0);
        check_eq("rst_invalid", {31'd0, invalid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_conv("w_pi",      2'b00, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 24);
        check_eq("b2b_done_cycle", {31'd0, done}, 32'd1);
        run_conv("w_m123",    2'b00, 32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 19);
        run_conv("w_2p31",    2'b00, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2);
        run_conv("w_m2p31",   2'b00, 32'hCF00_0000, 32'h8000_0000, 1'b0, 2);
        run_conv("w_nan",     2'b00, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 2);
        run_conv("w_half",    2'b00, 32'h3F00_0000, 32'h0000_0000, 1'b0, 2);
        run_conv("wu_nan",    2'b01, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b1, 2);
        run_conv("wu_m1",     2'b01, 32'hBF80_0000, 32'h0000_0000, 1'b1, 2);
        run_conv("wu_mhalf",  2'b01, 32'hBF00_0000, 32'h0000_0000, 1'b0, 2);
        run_conv("wu_2p32",   2'b01, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 2);
        run_conv("wu_max",    2'b01, 32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 10);
        run_conv("sw_one",    2'b10, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33);
        run_conv("sw_min",    2'b10, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2);
        run_conv("sw_m123",   2'b10, 32'hFFFF_FF85, 32'hC2F6_0000, 1'b0, 27);
        run_conv("sw_zero",   2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 2);
        run_conv("swu_max",   2'b11, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1'b0, 2);

        // A start raised while busy must not spawn a second conversion.
        @(posedge clk); #1;
        op = 2'b00; operand = 32'h4049_0FDB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        op = 2'b10; operand = 32'h0000_0001; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        n_done = 0;
        got    = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                got = result;
            end
        end
        check_eq("ignore_done_count", 32'(n_done), 32'd1);
        check_eq("ignore_result", got, 32'h0000_0003);

        // Reset in the middle of SHIFT aborts the conversion silently.
        op = 2'b00; operand = 32'h4049_0FDB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy",    {31'd0, busy},    32'd0);
        check_eq("abort_done",    {31'd0, done},    32'd0);
        check_eq("abort_result",  result,           32'd0);
        check_eq("abort_invalid", {31'd0, invalid}, 32'd0);
        reset  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_eq("abort_no_done", 32'(n_done), 32'd0);
        run_conv("post_rst", 2'b00, 32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
